servo_ramp_ctrl: RTL and testbench

Multi-channel slew-rate limiter for servo PWM high-time values. Each channel moves its output duty toward a requested duty in steps of STEP counts, one step per duty_gap clocks, with range clamping and a snap mode. Outputs feed the PWM generators, one per servo joint, in the arm controller.

---
 rtl/servo_ramp_ctrl.sv | 87 ++++++++
 tb/tb_servo_ramp_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/servo_ramp_ctrl.sv
// Multi-channel servo duty slew-rate limiter: each channel walks duty_out toward
// a clamped target by STEP counts every duty_gap clocks, with snap and global hold.
module servo_ramp_ctrl #(
  parameter int unsigned NCH        = 4,
  parameter int unsigned W          = 20,
  parameter int unsigned GAP_W      = 12,
  parameter int unsigned STEP       = 1,
  parameter int unsigned DUTY_MIN   = 25000,
  parameter int unsigned DUTY_MAX   = 125000,
  parameter int unsigned RESET_DUTY = 75000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH*W-1:0]     duty_need,
  input  logic [NCH*GAP_W-1:0] duty_gap,
  input  logic [NCH-1:0]       snap,
  input  logic                 hold,
  output logic [NCH*W-1:0]     duty_out,
  output logic [NCH-1:0]       settled,
  output logic                 all_settled
);

  localparam logic [W-1:0] LP_MIN   = W'(DUTY_MIN);
  localparam logic [W-1:0] LP_MAX   = W'(DUTY_MAX);
  localparam logic [W-1:0] LP_RESET = W'(RESET_DUTY);
  localparam logic [W:0]   LP_STEP  = (W+1)'(STEP);

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic [W-1:0]     w_need;
    logic [W-1:0]     w_tgt;
    logic [GAP_W-1:0] w_gap;
    logic [GAP_W-1:0] w_gap_last;
    logic             w_up;
    logic [W:0]       w_diff;
    logic [W:0]       w_delta;
    logic [W:0]       w_next;
    logic [W-1:0]     r_duty;
    logic [GAP_W-1:0] r_cnt;

    assign w_need = duty_need[g*W +: W];
    assign w_gap  = duty_gap[g*GAP_W +: GAP_W];

    always_comb begin
      w_tgt = w_need;
      if (w_need < LP_MIN)      w_tgt = LP_MIN;
      else if (w_need > LP_MAX) w_tgt = LP_MAX;
    end

    // A gap of 0 behaves like 1: the step fires whenever the counter is 0.
    assign w_gap_last = (w_gap == '0) ? '0 : w_gap - GAP_W'(1);

    // Direction comes from the live target so a mid-ramp reversal takes effect
    // on the very next step; delta is limited so the step cannot overshoot.
    always_comb begin
      w_up    = (w_tgt > r_duty);
      w_diff  = w_up ? ({1'b0, w_tgt} - {1'b0, r_duty}) : ({1'b0, r_duty} - {1'b0, w_tgt});
      w_delta = (w_diff < LP_STEP) ? w_diff : LP_STEP;
      w_next  = w_up ? ({1'b0, r_duty} + w_delta) : ({1'b0, r_duty} - w_delta);
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_duty <= LP_RESET;
        r_cnt  <= '0;
      end else if (snap[g]) begin
        r_duty <= w_tgt;
        r_cnt  <= '0;
      end else if (hold) begin
        r_duty <= r_duty;
        r_cnt  <= r_cnt;
      end else if (r_duty == w_tgt) begin
        r_cnt  <= '0;
      end else if (r_cnt == w_gap_last) begin
        r_cnt  <= '0;
        r_duty <= w_next[W-1:0];
      end else begin
        r_cnt  <= r_cnt + GAP_W'(1);
      end
    end

    assign duty_out[g*W +: W] = r_duty;
    assign settled[g]         = (r_duty == w_tgt);
  end

  assign all_settled = &settled;

endmodule

// File: tb/tb_servo_ramp_ctrl.sv
// Directed bench for servo_ramp_ctrl: DUT A uses STEP=1, DUT B uses STEP=10;
// table rows for straight ramps and clamps, hand sequences for hold/snap/reversal/reset.
module tb_servo_ramp_ctrl;
  localparam int NCH   = 4;
  localparam int W     = 20;
  localparam int GAP_W = 12;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 hold = 1'b0;
  logic [NCH*W-1:0]     needA, needB, dutyA, dutyB;
  logic [NCH*GAP_W-1:0] gapA, gapB;
  logic [NCH-1:0]       snapA, snapB, setA, setB;
  logic                 allA, allB;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  servo_ramp_ctrl #(.NCH(NCH), .W(W), .GAP_W(GAP_W), .STEP(1)) dutA (
    .clk(clk), .rst_n(rst_n), .duty_need(needA), .duty_gap(gapA), .snap(snapA),
    .hold(hold), .duty_out(dutyA), .settled(setA), .all_settled(allA));

  servo_ramp_ctrl #(.NCH(NCH), .W(W), .GAP_W(GAP_W), .STEP(10)) dutB (
    .clk(clk), .rst_n(rst_n), .duty_need(needB), .duty_gap(gapB), .snap(snapB),
    .hold(hold), .duty_out(dutyB), .settled(setB), .all_settled(allB));

  typedef struct {
    int dut;
    int ch;
    int need;
    int gap;
    int adv;
    int exp_duty;
    int exp_set;
  } vec_t;

  vec_t tbl [18];

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int dA(input int ch);
    return int'(dutyA[ch*W +: W]);
  endfunction

  function automatic int dB(input int ch);
    return int'(dutyB[ch*W +: W]);
  endfunction

  task automatic setA_ch(input int ch, input int need, input int gap);
    needA[ch*W +: W]         = W'(need);
    gapA[ch*GAP_W +: GAP_W]  = GAP_W'(gap);
  endtask

  task automatic setB_ch(input int ch, input int need, input int gap);
    needB[ch*W +: W]         = W'(need);
    gapB[ch*GAP_W +: GAP_W]  = GAP_W'(gap);
  endtask

  initial begin
    // dut, ch, need, gap, advance edges, expected duty, expected settled
    tbl[0]  = '{0, 0,  75003, 4,    3,  75000, 0};
    tbl[1]  = '{0, 0,  75003, 4,    1,  75001, 0};
    tbl[2]  = '{0, 0,  75003, 4,    4,  75002, 0};
    tbl[3]  = '{0, 0,  75003, 4,    3,  75002, 0};
    tbl[4]  = '{0, 0,  75003, 4,    1,  75003, 1};
    tbl[5]  = '{0, 0,  75003, 4,    2,  75003, 1};
    tbl[6]  = '{1, 1,  75025, 1,    1,  75010, 0};
    tbl[7]  = '{1, 1,  75025, 1,    1,  75020, 0};
    tbl[8]  = '{1, 1,  75025, 1,    1,  75025, 1};
    tbl[9]  = '{1, 1,  75025, 1,    2,  75025, 1};
    tbl[10] = '{1, 2, 200000, 0,    1,  75010, 0};
    tbl[11] = '{1, 2, 200000, 0, 4998, 124990, 0};
    tbl[12] = '{1, 2, 200000, 0,    1, 125000, 1};
    tbl[13] = '{1, 2, 200000, 0,    3, 125000, 1};
    tbl[14] = '{1, 2,      0, 0,    1, 124990, 0};
    tbl[15] = '{1, 2,      0, 0, 9998,  25010, 0};
    tbl[16] = '{1, 2,      0, 0,    1,  25000, 1};
    tbl[17] = '{1, 2,      0, 0,    2,  25000, 1};

    needA = {NCH{20'd75000}};
    needB = {NCH{20'd75000}};
    gapA  = '0;
    gapB  = '0;
    snapA = '0;
    snapB = '0;

    #12;
    chk("reset_dutyA0", dA(0), 75000);
    chk("reset_dutyB3", dB(3), 75000);
    #10 rst_n = 1'b1;
    tick(2);
    for (int c = 0; c < NCH; c++) begin
      chk($sformatf("idle_dutyA%0d", c), dA(c), 75000);
      chk($sformatf("idle_dutyB%0d", c), dB(c), 75000);
    end
    chk("idle_settledA", int'(setA), 15);
    chk("idle_allA", int'(allA), 1);
    chk("idle_allB", int'(allB), 1);

    for (int i = 0; i < 18; i++) begin
      if (tbl[i].dut == 0) setA_ch(tbl[i].ch, tbl[i].need, tbl[i].gap);
      else                 setB_ch(tbl[i].ch, tbl[i].need, tbl[i].gap);
      tick(tbl[i].adv);
      if (tbl[i].dut == 0) begin
        chk($sformatf("row%0d_duty", i), dA(tbl[i].ch), tbl[i].exp_duty);
        chk($sformatf("row%0d_settled", i), int'(setA[tbl[i].ch]), tbl[i].exp_set);
      end else begin
        chk($sformatf("row%0d_duty", i), dB(tbl[i].ch), tbl[i].exp_duty);
        chk($sformatf("row%0d_settled", i), int'(setB[tbl[i].ch]), tbl[i].exp_set);
      end
    end
    for (int c = 1; c < NCH; c++)
      chk($sformatf("untouched_dutyA%0d", c), dA(c), 75000);

    // hold freezes ramps; snap on ch3 overrides it; counters resume in phase
    setA_ch(1, 75100, 3);
    setA_ch(2, 74900, 5);
    tick(2);
    chk("prehold_ch1", dA(1), 75000);
    hold = 1'b1;
    tick(20);
    chk("hold_ch1", dA(1), 75000);
    chk("hold_ch2", dA(2), 75000);
    chk("hold_all_settled", int'(allA), 0);
    setA_ch(3, 130000, 0);
    snapA[3] = 1'b1;
    tick(1);
    chk("snap_in_hold_ch3", dA(3), 125000);
    chk("snap_in_hold_ch1", dA(1), 75000);
    snapA[3] = 1'b0;
    tick(1);
    chk("after_snap_ch3", dA(3), 125000);
    chk("after_snap_set3", int'(setA[3]), 1);
    hold = 1'b0;
    tick(1);
    chk("resume_ch1_step", dA(1), 75001);
    chk("resume_ch2_e1", dA(2), 75000);
    tick(1);
    chk("resume_ch2_e2", dA(2), 75000);
    tick(1);
    chk("resume_ch2_e3", dA(2), 74999);
    tick(1);
    chk("resume_ch1_e4", dA(1), 75002);

    // reversal mid-ramp on ch0
    setA_ch(0, 75000, 4);
    snapA[0] = 1'b1;
    tick(1);
    chk("rev_snap_ch0", dA(0), 75000);
    snapA[0] = 1'b0;
    setA_ch(0, 75010, 4);
    tick(8);
    chk("rev_up_ch0", dA(0), 75002);
    tick(2);
    setA_ch(0, 74990, 4);
    tick(1);
    chk("rev_wait_ch0", dA(0), 75002);
    tick(1);
    chk("rev_first_down", dA(0), 75001);
    tick(43);
    chk("rev_near_ch0", dA(0), 74991);
    chk("rev_near_set0", int'(setA[0]), 0);
    tick(1);
    chk("rev_done_ch0", dA(0), 74990);
    chk("rev_done_set0", int'(setA[0]), 1);

    // asynchronous reset mid-ramp, sampled between edges
    setA_ch(0, 75100, 2);
    tick(10);
    chk("preRst_ch0", dA(0), 74995);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_A0", dA(0), 75000);
    chk("async_rst_A3", dA(3), 75000);
    chk("async_rst_B2", dB(2), 75000);
    @(negedge clk);
    rst_n = 1'b1;
    tick(1);
    chk("post_rst_e1", dA(0), 75000);
    tick(1);
    chk("post_rst_e2", dA(0), 75001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
